// File: rtl/pc_unit.sv
// pc_unit: program counter for the RiSC-16 fetch stage.
// Holds the PC, produces PC+1 and selects the next PC from the sequential,
// branch-immediate, ALU-jump or return-stack source, with stall support.
// Optional feature macro PC_RAS_EN: when defined, a circular return-address
// stack handles call/return; when undefined, sel=11 falls back to PC+1,
// call is ignored and the stack flags are constant (empty=1, full=0, err=0).
module pc_unit #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] imm_target,
   input  logic [WIDTH-1:0] alu_target,
   input  logic             call,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus1,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   logic [WIDTH-1:0] pc_reg;
   logic [WIDTH-1:0] pc_next;

   assign pc       = pc_reg;
   assign pc_plus1 = pc_reg + WIDTH'(1);

`ifdef PC_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   // Entry storage; top_reg indexes the most recently pushed entry.
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_reg, top_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             err_reg, err_next;
   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic             ras_has;
   logic             ras_is_full;

   assign ras_has     = (count_reg != '0);
   assign ras_is_full = (count_reg == CNT_W'(RAS_DEPTH));
   assign ras_empty   = ~ras_has;
   assign ras_full    = ras_is_full;
   assign ras_err     = err_reg;

   // Next-PC selection plus push/pop bookkeeping; a stall freezes everything.
   always_comb begin
      pc_next    = pc_reg;
      top_next   = top_reg;
      count_next = count_reg;
      err_next   = err_reg;
      wr_en      = 1'b0;
      wr_addr    = top_reg + 1'b1;
      if (!stall) begin
         case (sel)
            2'b00:   pc_next = pc_plus1;
            2'b01:   pc_next = imm_target;
            2'b10:   pc_next = alu_target;
            default: pc_next = ras_has ? ras_mem[top_reg] : pc_plus1;
         endcase
         if (sel == 2'b11) begin
            if (!ras_has) begin
               // Underflow: fall through to PC+1; a simultaneous call still pushes.
               err_next = 1'b1;
               if (call) begin
                  wr_en      = 1'b1;
                  top_next   = top_reg + 1'b1;
                  count_next = CNT_W'(1);
               end
            end else if (call) begin
               // Return and call together: replace the top entry in place.
               wr_en   = 1'b1;
               wr_addr = top_reg;
            end else begin
               top_next   = top_reg - 1'b1;
               count_next = count_reg - 1'b1;
            end
         end else if (call) begin
            // Push; when full the write lands on the oldest slot.
            wr_en    = 1'b1;
            top_next = top_reg + 1'b1;
            if (ras_is_full) begin
               err_next = 1'b1;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end
      end
   end

   // Stack entry write; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         ras_mem[wr_addr] <= pc_plus1;
      end
   end

   // Stack pointer, occupancy and sticky error state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_reg   <= '0;
         count_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         top_reg   <= top_next;
         count_reg <= count_next;
         err_reg   <= err_next;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = call ^ (RAS_DEPTH == 0);

   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
   assign ras_err   = 1'b0;

   // Next-PC selection without a return stack: sel=11 behaves as sequential.
   always_comb begin
      pc_next = pc_reg;
      if (!stall) begin
         case (sel)
            2'b01:   pc_next = imm_target;
            2'b10:   pc_next = alu_target;
            default: pc_next = pc_plus1;
         endcase
      end
   end
`endif

   // Architectural PC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg <= RESET_VECTOR;
      end else begin
         pc_reg <= pc_next;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed sequences with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_pc_unit;
   localparam int W = 16;
   localparam int D = 4;
`ifdef PC_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         stall = 1'b0;
   logic [1:0]   sel = 2'b00;
   logic [W-1:0] imm_target = '0;
   logic [W-1:0] alu_target = '0;
   logic         call = 1'b0;
   logic [W-1:0] pc, pc_plus1;
   logic         ras_empty, ras_full, ras_err;

   pc_unit #(.WIDTH(W), .RESET_VECTOR(16'h0000), .RAS_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .stall(stall), .sel(sel),
      .imm_target(imm_target), .alu_target(alu_target), .call(call),
      .pc(pc), .pc_plus1(pc_plus1),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Model: PC value, stack as a queue (oldest at front), sticky error.
   logic [W-1:0] m_pc;
   logic [W-1:0] m_stack[$];
   logic         m_err;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000;
      m_stack.delete();
      m_err = 1'b0;
   endtask

   task automatic model_step();
      logic [W-1:0] p1;
      p1 = m_pc + 16'd1;
      if (stall) return;
      case (sel)
         2'b00: m_pc = p1;
         2'b01: m_pc = imm_target;
         2'b10: m_pc = alu_target;
         default: m_pc = (RAS_ON && m_stack.size() > 0) ? m_stack[$] : p1;
      endcase
      if (RAS_ON) begin
         if (sel == 2'b11) begin
            if (m_stack.size() == 0) begin
               m_err = 1'b1;
               if (call) m_stack.push_back(p1);
            end else begin
               void'(m_stack.pop_back());
               if (call) m_stack.push_back(p1);
            end
         end else if (call) begin
            m_stack.push_back(p1);
            if (m_stack.size() > D) begin
               void'(m_stack.pop_front());
               m_err = 1'b1;
            end
         end
      end
   endtask

   // Compare all DUT outputs against the model.
   task automatic check_model();
      logic e_empty, e_full;
      e_empty = RAS_ON ? (m_stack.size() == 0) : 1'b1;
      e_full  = RAS_ON ? (m_stack.size() == D) : 1'b0;
      chk("pc", pc, m_pc);
      chk("pc_plus1", pc_plus1, m_pc + 16'd1);
      chk("ras_empty", {15'd0, ras_empty}, {15'd0, e_empty});
      chk("ras_full", {15'd0, ras_full}, {15'd0, e_full});
      chk("ras_err", {15'd0, ras_err}, {15'd0, m_err});
      $display("cyc t=%0t rst=%b stall=%b sel=%b call=%b -> pc=%h empty=%b full=%b err=%b",
               $time, rst, stall, sel, call, pc, ras_empty, ras_full, ras_err);
   endtask

   // One clock: drive at negedge, model at posedge, check at next negedge.
   task automatic cycle(input logic s, input logic [1:0] se, input logic [W-1:0] it,
                        input logic [W-1:0] at, input logic c);
      stall = s; sel = se; imm_target = it; alu_target = at; call = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   // Reset asserted mid low phase; visible before the next rising edge.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_pc", pc, 16'h0000);
      @(negedge clk);
      check_model();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      chk("reset_pc", pc, 16'h0000);
      chk("reset_pc_plus1", pc_plus1, 16'h0001);
      @(negedge clk);
      check_model();
      rst = 1'b0;

      // Sequential counting and async reset
      cycle(0, 2'b00, 0, 0, 0); chk("seq1", pc, 16'h0001);
      cycle(0, 2'b00, 0, 0, 0); chk("seq2", pc, 16'h0002);
      cycle(0, 2'b00, 0, 0, 0); chk("seq3", pc, 16'h0003);
      async_reset();

      // Branch, jump, return with empty stack
      cycle(0, 2'b01, 16'h1234, 0, 0); chk("imm", pc, 16'h1234);
      cycle(0, 2'b10, 0, 16'hABCD, 0); chk("alu", pc, 16'hABCD);
      cycle(0, 2'b11, 0, 0, 0);        chk("pop_empty", pc, 16'hABCE);
      chk("pop_empty_err", {15'd0, ras_err}, {15'd0, RAS_ON});
      async_reset();

      // Call then return
      cycle(0, 2'b10, 0, 16'h0010, 0);
      cycle(0, 2'b10, 0, 16'h0200, 1); chk("call_pc", pc, 16'h0200);
      chk("call_empty", {15'd0, ras_empty}, {15'd0, !RAS_ON});
      cycle(0, 2'b11, 0, 0, 0);        chk("ret_pc", pc, RAS_ON ? 16'h0011 : 16'h0201);
      chk("ret_empty", {15'd0, ras_empty}, 16'd1);
      chk("ret_err", {15'd0, ras_err}, 16'd0);
      async_reset();

      // Five calls overflow a four-deep stack, then four returns
      cycle(0, 2'b10, 0, 16'h0010, 0);
      for (int k = 1; k <= 5; k++) cycle(0, 2'b10, 0, 16'(16 * (k + 1)), 1);
      chk("ovf_full", {15'd0, ras_full}, {15'd0, RAS_ON});
      chk("ovf_err", {15'd0, ras_err}, {15'd0, RAS_ON});
      for (int i = 0; i < 4; i++) begin
         cycle(0, 2'b11, 0, 0, 0);
         chk("ovf_pop", pc, RAS_ON ? 16'(16'h0051 - 16 * i) : 16'(16'h0061 + i));
      end
      chk("ovf_drained", {15'd0, ras_empty}, 16'd1);

      // Stall freezes everything
      for (int i = 0; i < 3; i++) begin
         cycle(1, 2'b10, 0, 16'h7777, 1);
         chk("stall_pc", pc, RAS_ON ? 16'h0021 : 16'h0064);
      end
      chk("stall_empty", {15'd0, ras_empty}, 16'd1);
      // Wrap at all-ones
      cycle(0, 2'b10, 0, 16'hFFFF, 0); chk("wrap_p1", pc_plus1, 16'h0000);
      cycle(0, 2'b00, 0, 0, 0);        chk("wrap_pc", pc, 16'h0000);
      async_reset();

      // Call with sequential select, then return
      cycle(0, 2'b10, 0, 16'h0007, 0);
      cycle(0, 2'b00, 0, 0, 1);        chk("seqcall_pc", pc, 16'h0008);
      cycle(0, 2'b11, 0, 0, 0);        chk("seqcall_ret", pc, RAS_ON ? 16'h0008 : 16'h0009);

      // Randomized run
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            async_reset();
         end else begin
            cycle($urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom), $urandom_range(0, 2) == 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
